multu_seq_ctrl: RTL and testbench

Multi-cycle sequencer for MULTU on the 32-bit ALU built from 1-bit slices. On a MULTU request it takes ownership of the ALU and drives one shift-add step per cycle using the slice adder path (ctl=MULTU, invb=0, cin=0). It holds the HI/LO product registers and serves MFHI/MFLO reads, stalling the requester while a multiply is in flight. Sits beside the ALU in the execute stage; the top level muxes ALU operands between the instruction path and this block.

---
 rtl/multu_seq_ctrl_pkg.sv | 30 +++
 rtl/multu_hilo_reg.sv | 48 ++++
 rtl/multu_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_multu_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/multu_seq_ctrl_pkg.sv
// Shared definitions for the MULTU sequencer and the 1-bit-slice ALU.
// Holds the default data width, the function codes used on the ALU
// control bus, the sequencer state encoding and a small decode helper.
package multu_seq_ctrl_pkg;

  localparam int WIDTH_DEF = 32;

  // Function codes shared with the ALU slice.
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // True for the two instructions that read the HI/LO product registers.
  function automatic logic is_mf(input logic [5:0] f);
    return (f == FUNCT_MFHI) || (f == FUNCT_MFLO);
  endfunction

endpackage

// File: rtl/multu_hilo_reg.sv
// HI/LO product registers plus the latched multiplicand.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears all regs)
//   load            capture a new operand pair: mcand<=load_mcand,
//                   hi<=0, lo<=load_lo
//   step            one shift-add step: {hi,lo} <= {cout,sum,lo} >> 1
//   load_mcand      multiplicand to latch on load
//   load_lo         multiplier to place in lo on load
//   sum, cout       ALU adder result for the current step
//   hi, lo, mcand   register contents
// Priority is rst > load > step.
module multu_hilo_reg
  import multu_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] load_mcand,
  input  logic [WIDTH-1:0] load_lo,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mcand
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
    end else if (load) begin
      mcand <= load_mcand;
      hi    <= '0;
      lo    <= load_lo;
    end else if (step) begin
      // The 2*WIDTH+1-bit value {cout,sum,lo} shifted right by one:
      // the carry lands in hi's MSB, sum[0] moves into lo's MSB and the
      // multiplier bit just consumed (lo[0]) falls off.
      hi <= {cout, sum[WIDTH-1:1]};
      lo <= {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multu_seq_ctrl.sv
// Multi-cycle MULTU sequencer for the execute-stage ALU.
// On an accepted MULTU it takes over the ALU operands and runs one
// shift-add step per cycle for WIDTH cycles, then pulses done. It also
// serves MFHI/MFLO reads from the HI/LO registers.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   funct, start       instruction function code and its valid
//   src_a, src_b       multiplicand (rs), multiplier (rt)
//   alu_sum, alu_cout  ALU adder result fed back for each step
//   alu_own            sequencer drives alu_ctl/alu_a/alu_b this cycle
//   alu_ctl, alu_a, alu_b, alu_invb, alu_cin   ALU control and operands
//   busy, done, stall  multiply in flight, completion pulse, read stall
//   hi, lo, rd_data    product registers and MFHI/MFLO read data
//
// Handshake: start is a single-cycle request with no ready. A MULTU is
// accepted only when the sequencer is idle; in RUN or FIN it is dropped
// and the requester must retry. An MFHI/MFLO issued while busy raises
// stall in the same cycle and must be held until stall falls; rd_data
// is meaningful only when stall is low.
module multu_seq_ctrl
  import multu_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       funct,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_cout,
  output logic             alu_own,
  output logic [5:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_invb,
  output logic             alu_cin,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  if ((2 ** CNT_W) <= WIDTH) begin : g_cnt_check
    $error("CNT_W too small for WIDTH");
  end

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             busy_q;
  logic             done_q;
  logic             own_q;
  logic [WIDTH-1:0] mcand;
  logic             accept;
  logic             step_en;

  assign accept  = (state == ST_IDLE) && start && (funct == FUNCT_MULTU);
  assign step_en = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      own_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_RUN;
            count  <= '0;
            busy_q <= 1'b1;
            own_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          count <= count + CNT_W'(1);
          if (count == LAST_STEP) begin
            state  <= ST_FIN;
            busy_q <= 1'b0;
            own_q  <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          own_q  <= 1'b0;
        end
      endcase
    end
  end

  multu_hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .step       (step_en),
    .load_mcand (src_a),
    .load_lo    (src_b),
    .sum        (alu_sum),
    .cout       (alu_cout),
    .hi         (hi),
    .lo         (lo),
    .mcand      (mcand)
  );

  // own_q is high exactly while in RUN, so it gates the operand mux.
  assign alu_own  = own_q;
  assign alu_ctl  = own_q ? FUNCT_MULTU : 6'b000000;
  assign alu_a    = own_q ? hi : '0;
  assign alu_b    = (own_q && lo[0]) ? mcand : '0;
  assign alu_invb = 1'b0;
  assign alu_cin  = 1'b0;

  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = start && busy_q && is_mf(funct);

  always_comb begin
    rd_data = '0;
    if (funct == FUNCT_MFHI)      rd_data = hi;
    else if (funct == FUNCT_MFLO) rd_data = lo;
  end

endmodule

// File: tb/tb_multu_seq_ctrl.sv
// Directed bench for multu_seq_ctrl with a behavioural adder standing in
// for the slice ALU.
module tb_multu_seq_ctrl;
  localparam int W = 32;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [5:0]   funct = '0;
  logic         start = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [W-1:0] alu_sum;
  logic         alu_cout;
  logic         alu_own;
  logic [5:0]   alu_ctl;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_invb;
  logic         alu_cin;
  logic         busy;
  logic         done;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] rd_data;

  multu_seq_ctrl dut (
    .clk(clk), .rst(rst), .funct(funct), .start(start),
    .src_a(src_a), .src_b(src_b), .alu_sum(alu_sum), .alu_cout(alu_cout),
    .alu_own(alu_own), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_invb(alu_invb), .alu_cin(alu_cin), .busy(busy), .done(done),
    .stall(stall), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- ALU stand-in: a + (invb ? ~b : b) + cin ----
  logic [W:0] alu_full;
  assign alu_full = {1'b0, alu_a} + {1'b0, (alu_invb ? ~alu_b : alu_b)}
                  + {{W{1'b0}}, alu_cin};
  assign alu_sum  = alu_full[W-1:0];
  assign alu_cout = alu_full[W];

  // ---- scoreboard ----
  logic [2*W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---- driver tasks ----
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_own",  64'(alu_own), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
  endtask

  // Presents a MULTU request for one cycle (the edge after this call).
  task automatic start_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] exp_prod);
    @(negedge clk);
    start = 1'b1; funct = F_MULTU; src_a = a; src_b = b;
    exp_q.push_back(exp_prod);
  endtask

  // Counts RUN cycles until done, optionally injecting a request on RUN
  // cycle inj_cyc; then checks latency, result, pulse width and that a
  // MULTU offered during FIN is dropped.
  task automatic wait_done(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int inj_cyc, input logic [5:0] inj_f,
                           input logic [W-1:0] inj_a, input logic [W-1:0] inj_b);
    int busy_cycles = 0;
    bit got_done = 1'b0;
    logic [2*W-1:0] exp_prod;
    for (int c = 0; c < 100 && !got_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) got_done = 1'b1;
      else if (busy) begin
        busy_cycles++;
        if (busy_cycles == 1) begin
          check({name, "_own"}, 64'(alu_own), 64'd1);
          check({name, "_ctl"}, 64'(alu_ctl), 64'(F_MULTU));
          check({name, "_alu_a"}, 64'(alu_a), 64'd0);
          check({name, "_alu_b"}, 64'(alu_b), 64'(b[0] ? a : '0));
        end
        if (busy_cycles == inj_cyc) begin
          start = 1'b1; funct = inj_f; src_a = inj_a; src_b = inj_b;
          #1;
          if (inj_f == F_MFHI || inj_f == F_MFLO)
            check({name, "_stall_run"}, 64'(stall), 64'd1);
        end
      end
    end
    check({name, "_run_cycles"}, 64'(busy_cycles), 64'd32);
    check({name, "_done_seen"}, 64'(got_done), 64'd1);
    if (exp_q.size() == 0) begin
      check({name, "_exp_q_empty"}, 64'd1, 64'd0);
    end else begin
      exp_prod = exp_q.pop_front();
      check({name, "_hi"}, 64'(hi), 64'(exp_prod[2*W-1:W]));
      check({name, "_lo"}, 64'(lo), 64'(exp_prod[W-1:0]));
    end
    check({name, "_fin_own"}, 64'(alu_own), 64'd0);
    // MULTU offered in FIN must not be accepted.
    start = 1'b1; funct = F_MULTU; src_a = 32'd7; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_pulse"}, 64'(done), 64'd0);
    check({name, "_fin_ignored"}, 64'(busy), 64'd0);
    check({name, "_hold"}, {hi, lo}, exp_prod);
  endtask

  task automatic read_req(input string name, input logic [5:0] f, input logic [W-1:0] exp_data);
    @(negedge clk);
    start = 1'b1; funct = f;
    #1;
    check({name, "_stall"}, 64'(stall), 64'd0);
    check({name, "_rd"}, 64'(rd_data), 64'(exp_data));
    @(negedge clk);
    start = 1'b0;
    check({name, "_no_start"}, 64'(busy), 64'd0);
  endtask

  // ---- directed sequence ----
  initial begin
    int busy_cnt;
    int done_cnt;
    do_reset();

    // 3 x 5
    start_mult(32'd3, 32'd5, 64'h0000_0000_0000_000F);
    wait_done("m3x5", 32'd3, 32'd5, 0, F_ADD, '0, '0);

    // all-ones squared: carry out every step
    start_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done("mff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, F_ADD, '0, '0);

    // 0x80000000 x 2, then reads in IDLE; ADD start must be ignored
    start_mult(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    wait_done("m80x2", 32'h8000_0000, 32'd2, 0, F_ADD, '0, '0);
    read_req("mflo", F_MFLO, 32'h0000_0000);
    read_req("mfhi_a", F_MFHI, 32'h0000_0001);
    read_req("add_rd", F_ADD, 32'h0000_0000);

    // MFHI during RUN cycle 10 stalls; after done it reads hi
    start_mult(32'h0001_0000, 32'h0003_0000, 64'h0000_0003_0000_0000);
    wait_done("mstall", 32'h0001_0000, 32'h0003_0000, 10, F_MFHI, '0, '0);
    read_req("mfhi_b", F_MFHI, 32'h0000_0003);

    // second MULTU (7 x 9) on RUN cycle 5 is ignored
    start_mult(32'd3, 32'd5, 64'h0000_0000_0000_000F);
    wait_done("mreissue", 32'd3, 32'd5, 5, F_MULTU, 32'd7, 32'd9);

    // reset on RUN cycle 20 aborts the multiply
    start_mult(32'h1234_5678, 32'h9ABC_DEF1, 64'd0);
    void'(exp_q.pop_back());
    busy_cnt = 0;
    for (int c = 0; c < 60 && busy_cnt < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
    end
    check("abort_reached", 64'(busy_cnt), 64'd20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_own",  64'(alu_own), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_idle", 64'(busy_cnt), 64'd0);

    // fresh multiply after abort
    start_mult(32'd6, 32'd7, 64'd42);
    wait_done("m6x7", 32'd6, 32'd7, 0, F_ADD, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
